seg7_digit_capture: RTL and testbench

- Receive side of the team's 7-segment display path. Accepts a stream of active-low 7-segment patterns, one digit per handshake, most significant digit first.
- Decodes each pattern back to a BCD digit and assembles a 4-digit BCD word.
- Converts the word to binary with a sequential multiply-by-10 accumulator.
- Used to verify display drivers and to read segment buses back into arithmetic logic.

---
 rtl/seg7_digit_capture_if.sv | 23 ++
 rtl/seg7_digit_capture.sv | 117 +++++++++++
 tb/tb_seg7_digit_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_digit_capture_if.sv
// Handshake and result bus for seg7_digit_capture.
// master: the producer/consumer side; slave: the capture block.
interface seg7_digit_capture_if;
  logic [0:6]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic        out_ack;
  logic [15:0] bcd_out;
  logic [13:0] bin_out;
  logic        out_valid;
  logic        err;
  logic [2:0]  digit_count;

  modport master (
    output seg_in, seg_valid, out_ack,
    input  seg_ready, bcd_out, bin_out, out_valid, err, digit_count
  );

  modport slave (
    input  seg_in, seg_valid, out_ack,
    output seg_ready, bcd_out, bin_out, out_valid, err, digit_count
  );
endinterface

// File: rtl/seg7_digit_capture.sv
// seg7_digit_capture: reads a stream of active-low 7-segment patterns
// (MSD first), rebuilds a 4-digit BCD word and converts it to binary
// with a shift-add multiply-by-10 accumulator.
module seg7_digit_capture #(
  parameter int unsigned NDIG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_digit_capture_if.slave  bus
);

  typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;

  state_t      state;
  logic [15:0] bcd_q;
  logic [13:0] bin_q;
  logic [13:0] acc;
  logic [1:0]  cnv_idx;
  logic        out_valid_q;
  logic        err_q;
  logic [2:0]  digit_count_q;

  logic [3:0]  dec_digit;
  logic        dec_bad;
  logic [3:0]  cnv_digit;
  logic [13:0] acc_next;

  // Pattern decode; blank reads as 0 without flagging an error.
  always_comb begin
    dec_digit = 4'd0;
    dec_bad   = 1'b0;
    case (bus.seg_in)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0001100: dec_digit = 4'd9;
      7'b1111111: dec_digit = 4'd0;
      default:    dec_bad   = 1'b1;
    endcase
  end

  // Digit for the current conversion step (MSD first) and acc*10 + digit.
  always_comb begin
    cnv_digit = bcd_q[15:12];
    case (cnv_idx)
      2'd0: cnv_digit = bcd_q[15:12];
      2'd1: cnv_digit = bcd_q[11:8];
      2'd2: cnv_digit = bcd_q[7:4];
      2'd3: cnv_digit = bcd_q[3:0];
      default: cnv_digit = bcd_q[15:12];
    endcase
    acc_next = (acc << 3) + (acc << 1) + {10'd0, cnv_digit};
  end

  // Ready only in COLLECT and never while reset is held.
  assign bus.seg_ready   = (state == COLLECT) && !rst;
  assign bus.bcd_out     = bcd_q;
  assign bus.bin_out     = bin_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.err         = err_q;
  assign bus.digit_count = digit_count_q;

  // Control FSM: collect four digits, convert for four cycles, hold until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COLLECT;
      bcd_q         <= '0;
      bin_q         <= '0;
      acc           <= '0;
      cnv_idx       <= '0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      digit_count_q <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.seg_valid) begin
            bcd_q         <= {bcd_q[11:0], dec_digit};
            digit_count_q <= digit_count_q + 3'd1;
            if (dec_bad) err_q <= 1'b1;
            if (digit_count_q == 3'(NDIG - 1)) begin
              state   <= CONVERT;
              cnv_idx <= '0;
              acc     <= '0;
            end
          end
        end
        CONVERT: begin
          acc     <= acc_next;
          cnv_idx <= cnv_idx + 2'd1;
          if (cnv_idx == 2'd3) begin
            bin_q       <= acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ack) begin
            state         <= COLLECT;
            out_valid_q   <= 1'b0;
            digit_count_q <= '0;
            bcd_q         <= '0;
            err_q         <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_digit_capture.sv
// Directed bench for seg7_digit_capture with hand-computed expectations.
module tb_seg7_digit_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_digit_capture_if bus ();

  seg7_digit_capture #(.NDIG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                         P9 = 7'b0001100, PBLANK = 7'b1111111,
                         PBAD = 7'b1111110;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer; entered and left #1 after a rising edge.
  task automatic xfer(input logic [6:0] pat);
    bus.seg_in    = pat;
    bus.seg_valid = 1'b1;
    @(posedge clk); #1;
    bus.seg_valid = 1'b0;
  endtask

  task automatic word(input logic [6:0] a, input logic [6:0] b,
                      input logic [6:0] c, input logic [6:0] d);
    xfer(a); xfer(b); xfer(c); xfer(d);
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_valid(output int unsigned edges);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic ack_and_check(input string tag);
    bus.out_ack = 1'b1;
    @(posedge clk); #1;
    bus.out_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ack_cnt"},   32'(bus.digit_count), 32'd0);
    check({tag, "_ack_bcd"},   32'(bus.bcd_out), 32'h0);
    check({tag, "_ack_err"},   32'(bus.err), 32'd0);
    check({tag, "_ack_ready"}, 32'(bus.seg_ready), 32'd1);
  endtask

  int unsigned n;
  int unsigned xfers;

  initial begin
    bus.seg_in    = PBLANK;
    bus.seg_valid = 1'b0;
    bus.out_ack   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.seg_ready), 32'd0);
    check("rst_bcd",   32'(bus.bcd_out), 32'h0);
    check("rst_bin",   32'(bus.bin_out), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err",   32'(bus.err), 32'd0);
    check("rst_cnt",   32'(bus.digit_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", 32'(bus.seg_ready), 32'd1);

    // 1: 1234
    word(P1, P2, P3, P4);
    check("t1_cnt4",  32'(bus.digit_count), 32'd4);
    check("t1_ready", 32'(bus.seg_ready), 32'd0);
    wait_valid(n);
    check("t1_latency", n, 32'd4);
    check("t1_bcd", 32'(bus.bcd_out), 32'h1234);
    check("t1_bin", 32'(bus.bin_out), 32'd1234);
    check("t1_err", 32'(bus.err), 32'd0);
    ack_and_check("t1");

    // 2: 9999
    word(P9, P9, P9, P9);
    wait_valid(n);
    check("t2_latency", n, 32'd4);
    check("t2_bcd", 32'(bus.bcd_out), 32'h9999);
    check("t2_bin", 32'(bus.bin_out), 32'd9999);
    ack_and_check("t2");
    check("t2_bin_held", 32'(bus.bin_out), 32'd9999);

    // 3: bad pattern -> err sticky until ack
    xfer(P5);
    check("t3_err0", 32'(bus.err), 32'd0);
    xfer(PBAD);
    check("t3_err1", 32'(bus.err), 32'd1);
    xfer(P0);
    xfer(P7);
    wait_valid(n);
    check("t3_bcd", 32'(bus.bcd_out), 32'h5007);
    check("t3_bin", 32'(bus.bin_out), 32'd5007);
    check("t3_err", 32'(bus.err), 32'd1);
    ack_and_check("t3");

    // 4: leading blanks
    word(PBLANK, PBLANK, P4, P2);
    wait_valid(n);
    check("t4_bcd", 32'(bus.bcd_out), 32'h0042);
    check("t4_bin", 32'(bus.bin_out), 32'd42);
    check("t4_err", 32'(bus.err), 32'd0);
    ack_and_check("t4");

    // 5: seg_valid held high across CONVERT and DONE
    bus.seg_in    = P8;
    bus.seg_valid = 1'b1;
    xfers = 0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (bus.seg_ready) xfers++;
      @(posedge clk); #1;
      n++;
    end
    check("t5_xfers", xfers, 32'd4);
    check("t5_bcd",   32'(bus.bcd_out), 32'h8888);
    check("t5_bin",   32'(bus.bin_out), 32'd8888);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t5_done_ready", 32'(bus.seg_ready), 32'd0);
      check("t5_done_cnt",   32'(bus.digit_count), 32'd4);
    end
    bus.out_ack = 1'b1;
    @(posedge clk); #1;
    bus.out_ack = 1'b0;
    check("t5_ack_cnt", 32'(bus.digit_count), 32'd0);
    check("t5_ack_bcd", 32'(bus.bcd_out), 32'h0);
    @(posedge clk); #1;
    check("t5_fresh_cnt", 32'(bus.digit_count), 32'd1);
    check("t5_fresh_bcd", 32'(bus.bcd_out), 32'h0008);
    wait_valid(n);
    bus.seg_valid = 1'b0;
    check("t5_latency2", n, 32'd7);
    check("t5_bcd2", 32'(bus.bcd_out), 32'h8888);
    check("t5_bin2", 32'(bus.bin_out), 32'd8888);
    ack_and_check("t5");

    // 6a: reset after two transfers
    xfer(P3);
    xfer(P6);
    check("t6_cnt2", 32'(bus.digit_count), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_cnt",   32'(bus.digit_count), 32'd0);
    check("t6_rst_bcd",   32'(bus.bcd_out), 32'h0);
    check("t6_rst_ready", 32'(bus.seg_ready), 32'd0);
    rst = 1'b0;
    #1;
    word(P2, P0, P2, P5);
    wait_valid(n);
    check("t6_latency", n, 32'd4);
    check("t6_bcd", 32'(bus.bcd_out), 32'h2025);
    check("t6_bin", 32'(bus.bin_out), 32'd2025);
    check("t6_err", 32'(bus.err), 32'd0);
    ack_and_check("t6");

    // 6b: reset during CONVERT suppresses the result
    word(P1, P1, P1, P1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check("t6b_no_valid", n, 32'd0);
    check("t6b_cnt",   32'(bus.digit_count), 32'd0);
    check("t6b_bin",   32'(bus.bin_out), 32'd0);
    check("t6b_ready", 32'(bus.seg_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
